// File: rtl/ber_monitor_pkg.sv
// ber_monitor_pkg: shared popcount and pointer sizing for the BER monitor
package ber_monitor_pkg;
    localparam int MAX_N = 1024;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_N; i++) c += 32'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/ber_channel.sv
// ber_channel: per-stream read pointer, two-stage error count and saturating totals
module ber_channel
    import ber_monitor_pkg::*;
#(
    parameter int N     = 17,
    parameter int CNT_W = 32,
    parameter int PW    = 3,
    parameter int EW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             obs_valid,
    input  logic [N-1:0]     obs_bits,
    input  logic [N-1:0]     ref_bits,
    input  logic [PW-1:0]    wr_ptr,
    output logic [PW-1:0]    rd_ptr,
    output logic             result_valid,
    output logic [EW-1:0]    last_errors,
    output logic [CNT_W-1:0] bit_err_total,
    output logic [CNT_W-1:0] frame_err_total,
    output logic [CNT_W-1:0] frame_total,
    output logic             underflow
);
    localparam int SW = (CNT_W > EW ? CNT_W : EW) + 1;
    localparam logic [CNT_W-1:0] CMAX = '1;
    logic          pending, accept, s1_valid;
    logic [EW-1:0] s1_cnt;
    logic [SW-1:0] bit_sum;
    assign pending = rd_ptr != wr_ptr;
    assign accept  = obs_valid && pending;
    assign bit_sum = SW'(bit_err_total) + SW'(s1_cnt);
    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != CMAX) ? v + CNT_W'(1) : v;
    endfunction
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr          <= '0;
            s1_valid        <= 1'b0;
            s1_cnt          <= '0;
            result_valid    <= 1'b0;
            last_errors     <= '0;
            bit_err_total   <= '0;
            frame_err_total <= '0;
            frame_total     <= '0;
            underflow       <= 1'b0;
        end else begin
            rd_ptr       <= rd_ptr + PW'(accept);
            s1_valid     <= accept && !clear;
            s1_cnt       <= EW'(popcount(MAX_N'(obs_bits ^ ref_bits)));
            result_valid <= s1_valid && !clear;
            if (clear) begin
                last_errors     <= '0;
                bit_err_total   <= '0;
                frame_err_total <= '0;
                frame_total     <= '0;
                underflow       <= 1'b0;
            end else begin
                if (obs_valid && !pending) underflow <= 1'b1;
                if (s1_valid) begin
                    last_errors     <= s1_cnt;
                    bit_err_total   <= bit_sum > SW'(CMAX) ? CMAX : bit_sum[CNT_W-1:0];
                    frame_total     <= inc(frame_total, 1'b1);
                    frame_err_total <= inc(frame_err_total, s1_cnt != '0);
                end
            end
        end
endmodule

// File: rtl/ber_monitor.sv
// ber_monitor: shared reference-frame buffer feeding independent per-channel bit-error counters
module ber_monitor
    import ber_monitor_pkg::*;
#(
    parameter int N        = 17,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clear,
    input  logic                                      ref_valid,
    output logic                                      ref_ready,
    input  logic                                      ref_x [N],
    input  logic [CHANNELS-1:0]                       obs_valid,
    input  logic                                      obs_x [CHANNELS][N],
    output logic [CHANNELS-1:0]                       result_valid,
    output logic [CHANNELS-1:0][$clog2(N+1)-1:0]      last_errors,
    output logic [CHANNELS-1:0][CNT_W-1:0]            bit_err_total,
    output logic [CHANNELS-1:0][CNT_W-1:0]            frame_err_total,
    output logic [CHANNELS-1:0][CNT_W-1:0]            frame_total,
    output logic                                      overflow,
    output logic [CHANNELS-1:0]                       underflow
);
    localparam int PW = ptr_w(DEPTH);
    localparam int EW = $clog2(N + 1);
    logic [N-1:0]                  mem [DEPTH];
    logic [N-1:0]                  ref_vec;
    logic [CHANNELS-1:0][N-1:0]    obs_vec;
    logic [PW-1:0]                 wr_ptr, max_occ;
    logic [CHANNELS-1:0][PW-1:0]   rd_ptr;
    logic                          wr_en;
    // occupancy is set by whichever channel lags furthest behind the writer
    always_comb begin
        max_occ = '0;
        for (int c = 0; c < CHANNELS; c++)
            max_occ = (wr_ptr - rd_ptr[c]) > max_occ ? wr_ptr - rd_ptr[c] : max_occ;
    end
    assign ref_ready = max_occ < PW'(DEPTH);
    assign wr_en     = ref_valid && ref_ready;
    for (genvar b = 0; b < N; b++) begin : g_ref
        assign ref_vec[b] = ref_x[b];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(wr_en);
            overflow <= !clear && (overflow || (ref_valid && !ref_ready));
        end
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[PW-2:0]] <= ref_vec;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar b = 0; b < N; b++) begin : g_obs
            assign obs_vec[c][b] = obs_x[c][b];
        end
        ber_channel #(.N(N), .CNT_W(CNT_W), .PW(PW), .EW(EW)) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .clear           (clear),
            .obs_valid       (obs_valid[c]),
            .obs_bits        (obs_vec[c]),
            .ref_bits        (mem[rd_ptr[c][PW-2:0]]),
            .wr_ptr          (wr_ptr),
            .rd_ptr          (rd_ptr[c]),
            .result_valid    (result_valid[c]),
            .last_errors     (last_errors[c]),
            .bit_err_total   (bit_err_total[c]),
            .frame_err_total (frame_err_total[c]),
            .frame_total     (frame_total[c]),
            .underflow       (underflow[c])
        );
    end
endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: directed stimulus against a frame-level model of the BER monitor
module tb_ber_monitor;
    localparam int N = 17, C = 2, D = 4, EW = 5;
    localparam logic [N-1:0] P = 17'h09249;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic clk = 0, rst_n = 0, clear = 0, ref_valid = 0;
    logic ref_ready, overflow;
    logic ref_x [N];
    logic [C-1:0] obs_valid = '0, result_valid, underflow;
    logic obs_x [C][N];
    logic [C-1:0][EW-1:0] last_errors;
    logic [C-1:0][31:0] bit_err_total, frame_err_total, frame_total;

    logic r2_valid = 0, r2_ready, ovf2;
    logic r2_x [N];
    logic [0:0] o2_valid = '0, rv2, und2;
    logic o2_x [1][N];
    logic [0:0][EW-1:0] le2;
    logic [0:0][3:0] be2, fe2, ft2;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    ber_monitor #(.N(N), .CHANNELS(C), .DEPTH(D), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ref_valid(ref_valid), .ref_ready(ref_ready),
        .ref_x(ref_x), .obs_valid(obs_valid), .obs_x(obs_x), .result_valid(result_valid),
        .last_errors(last_errors), .bit_err_total(bit_err_total), .frame_err_total(frame_err_total),
        .frame_total(frame_total), .overflow(overflow), .underflow(underflow));

    ber_monitor #(.N(N), .CHANNELS(1), .DEPTH(D), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ref_valid(r2_valid), .ref_ready(r2_ready),
        .ref_x(r2_x), .obs_valid(o2_valid), .obs_x(o2_x), .result_valid(rv2),
        .last_errors(le2), .bit_err_total(be2), .frame_err_total(fe2),
        .frame_total(ft2), .overflow(ovf2), .underflow(und2));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: every written reference kept in order; each channel indexes it by frames consumed.
    logic [N-1:0] hist[$];
    int wr_n = 0, cyc = 0;
    int rd_n[C], m_last[C];
    longint m_bit[C], m_fe[C], m_ft[C];
    bit m_rv[C], m_und[C], m_ovf = 0;
    int q_due[C][$], q_cnt[C][$];

    function automatic bit m_ready();
        int lo;
        lo = rd_n[0];
        for (int c = 1; c < C; c++) if (rd_n[c] < lo) lo = rd_n[c];
        return (wr_n - lo) < D;
    endfunction
    function automatic logic [N-1:0] ref_word();
        logic [N-1:0] w;
        for (int b = 0; b < N; b++) w[b] = ref_x[b];
        return w;
    endfunction
    function automatic logic [N-1:0] obs_word(input int c);
        logic [N-1:0] w;
        for (int b = 0; b < N; b++) w[b] = obs_x[c][b];
        return w;
    endfunction
    function automatic longint sat(input longint v);
        return v > CMAX ? CMAX : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int wr0, cnt;
        bit rdy;
        if (!rst_n) begin
            hist.delete();
            wr_n = 0; m_ovf = 0; cyc = 0;
            for (int c = 0; c < C; c++) begin
                rd_n[c] = 0; m_bit[c] = 0; m_fe[c] = 0; m_ft[c] = 0; m_last[c] = 0;
                m_rv[c] = 0; m_und[c] = 0;
                q_due[c].delete(); q_cnt[c].delete();
            end
        end else begin
            wr0 = wr_n;
            rdy = m_ready();
            cyc++;
            for (int c = 0; c < C; c++) begin
                m_rv[c] = 0;
                if (clear) begin
                    m_bit[c] = 0; m_fe[c] = 0; m_ft[c] = 0; m_last[c] = 0; m_und[c] = 0;
                    q_due[c].delete(); q_cnt[c].delete();
                end else if (q_due[c].size() > 0 && q_due[c][0] == cyc) begin
                    cnt = q_cnt[c].pop_front();
                    void'(q_due[c].pop_front());
                    m_rv[c] = 1;
                    m_last[c] = cnt;
                    m_bit[c] = sat(m_bit[c] + cnt);
                    m_ft[c] = sat(m_ft[c] + 1);
                    m_fe[c] = sat(m_fe[c] + (cnt != 0 ? 1 : 0));
                end
                if (obs_valid[c]) begin
                    if (rd_n[c] < wr0) begin
                        cnt = $countones(obs_word(c) ^ hist[rd_n[c]]);
                        rd_n[c]++;
                        if (!clear) begin
                            q_due[c].push_back(cyc + 1);
                            q_cnt[c].push_back(cnt);
                        end
                    end else if (!clear) m_und[c] = 1;
                end
            end
            if (clear) m_ovf = 0;
            if (ref_valid) begin
                if (rdy) begin
                    hist.push_back(ref_word());
                    wr_n++;
                end else if (!clear) m_ovf = 1;
            end
        end
    end

    always @(negedge clk) if (rst_n && chk_en) begin
        chk("ref_ready", ref_ready, m_ready());
        chk("overflow", overflow, m_ovf);
        for (int c = 0; c < C; c++) begin
            chk("result_valid", result_valid[c], m_rv[c]);
            chk("underflow", underflow[c], m_und[c]);
            chk("last_errors", last_errors[c], m_last[c]);
            chk("bit_err_total", bit_err_total[c], m_bit[c]);
            chk("frame_err_total", frame_err_total[c], m_fe[c]);
            chk("frame_total", frame_total[c], m_ft[c]);
        end
    end

    task automatic drive(input bit rv, input logic [N-1:0] r, input logic [C-1:0] ov,
                         input logic [N-1:0] o0, input logic [N-1:0] o1, input bit clr = 0);
        ref_valid = rv; obs_valid = ov; clear = clr;
        for (int b = 0; b < N; b++) begin
            ref_x[b] = r[b]; obs_x[0][b] = o0[b]; obs_x[1][b] = o1[b];
        end
        @(negedge clk);
        ref_valid = 0; obs_valid = '0; clear = 0;
    endtask

    logic [N-1:0] rr [4] = '{17'h1ABCD, 17'h00F0F, 17'h1FFFF, 17'h00001};

    initial begin
        for (int b = 0; b < N; b++) begin
            ref_x[b] = 0; obs_x[0][b] = 0; obs_x[1][b] = 0; r2_x[b] = 0; o2_x[0][b] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset ref_ready", ref_ready, 1);
        chk("reset frame_total", frame_total[0], 0);
        rst_n = 1; chk_en = 1;

        drive(1, P, 2'b00, 0, 0);
        drive(0, 0, 2'b01, P, 0);
        chk("latency early rv0", result_valid[0], 0);
        @(negedge clk);
        chk("ident rv0", result_valid[0], 1);
        chk("ident last0", last_errors[0], 0);
        chk("ident ft0", frame_total[0], 1);
        chk("ident fe0", frame_err_total[0], 0);

        drive(0, 0, 2'b10, 0, P ^ 17'h10021);
        @(negedge clk);
        chk("flip last1", last_errors[1], 3);
        chk("flip be1", bit_err_total[1], 3);
        chk("flip fe1", frame_err_total[1], 1);
        chk("flip ft0", frame_total[0], 1);
        chk("flip be0", bit_err_total[0], 0);

        for (int i = 0; i < 4; i++) drive(1, rr[i], 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 2'b01, rr[i] ^ (i == 2 ? 17'h3 : 17'h0), 0);
        repeat (2) @(negedge clk);
        chk("full ref_ready", ref_ready, 0);
        drive(1, 17'h12345, 2'b00, 0, 0);
        chk("overflow set", overflow, 1);
        drive(0, 0, 2'b10, 0, rr[0] ^ 17'h1);
        chk("ready after ch1", ref_ready, 1);
        for (int i = 1; i < 4; i++) drive(0, 0, 2'b10, 0, rr[i]);
        repeat (2) @(negedge clk);

        drive(0, 0, 2'b00, 0, 0, 1);
        chk("clear be1", bit_err_total[1], 0);
        chk("clear overflow", overflow, 0);
        drive(0, 0, 2'b01, P, 0);
        chk("underflow0", underflow[0], 1);
        repeat (2) @(negedge clk);
        chk("underflow rv0", result_valid[0], 0);
        chk("underflow ft0", frame_total[0], 0);
        drive(0, 0, 2'b00, 0, 0, 1);
        chk("clear underflow0", underflow[0], 0);

        drive(1, P, 2'b00, 0, 0);
        drive(0, 0, 2'b11, P, P ^ 17'h1);
        drive(0, 0, 2'b00, 0, 0, 1);
        chk("clear wins rv", result_valid, 0);
        chk("clear wins ft1", frame_total[1], 0);

        drive(1, P, 2'b00, 0, 0);
        drive(0, 0, 2'b11, P, P ^ 17'h3);
        @(negedge clk);
        chk("simul rv", result_valid, 3);
        chk("simul last1", last_errors[1], 2);
        chk("simul ft1", frame_total[1], 1);

        drive(1, rr[0], 2'b00, 0, 0);
        drive(1, rr[1], 2'b00, 0, 0);
        drive(0, 0, 2'b01, rr[0], 0);
        #2 rst_n = 0;
        #1;
        chk("rst ref_ready", ref_ready, 1);
        chk("rst rv", result_valid, 0);
        chk("rst ft1", frame_total[1], 0);
        chk("rst last1", last_errors[1], 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post rst rv", result_valid, 0);
        end
        chk("post rst ref_ready", ref_ready, 1);

        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            for (int b = 0; b < N; b++) r2_x[b] = r[b];
            r2_valid = 1;
            @(negedge clk);
            r2_valid = 0;
            for (int b = 0; b < N; b++) o2_x[0][b] = ~r[b];
            o2_valid = 1'b1;
            @(negedge clk);
            o2_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("sat last", le2[0], 17);
        chk("sat be", be2[0], 15);
        chk("sat ft", ft2[0], 15);
        chk("sat fe", fe2[0], 15);
        chk("sat und", und2[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
